// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: serial two's-complement subtractor, one 4-bit nibble per cycle.
// Each nibble is summed in carry-select form: the low 2 bits ripple from the
// carry register, and the high 2 bits are formed for both carry-ins and then selected.
// Optional feature macro: NSUB_ADD_MODE_EN adds the port `op` (1 = subtract, 0 = add).
module nibble_serial_sub #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NSUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic [4*NIB-1:0] A,
  input  logic [4*NIB-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            carry_reg;
  logic [W-1:0]    opa_reg, opb_reg;
  logic            sub_reg;
  logic            op_in;
  logic            accept;
  logic            last;

  logic [3:0]      nib_a [NIB];
  logic [3:0]      nib_b [NIB];
  logic [3:0]      na, nb;
  logic [2:0]      lo, hi0, hi1, hi;
  logic [3:0]      nib_sum;
  logic            nib_cout;
  logic            top_cin;

`ifdef NSUB_ADD_MODE_EN
  assign op_in = op;
`else
  assign op_in = 1'b1;
`endif

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last   = (cnt_reg == LAST);
  assign busy   = (state_reg == BUSY);
  assign done   = (state_reg == DONE);

  // Split the operand registers into nibble lanes so the active lane is a plain mux.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_lane
      assign nib_a[gi] = opa_reg[4*gi +: 4];
      assign nib_b[gi] = opb_reg[4*gi +: 4];
    end
  endgenerate

  // Carry-select sum of the active nibble.
  always_comb begin
    na       = nib_a[cnt_reg];
    nb       = nib_b[cnt_reg];
    lo       = {1'b0, na[1:0]} + {1'b0, nb[1:0]} + {2'b00, carry_reg};
    hi0      = {1'b0, na[3:2]} + {1'b0, nb[3:2]};
    hi1      = hi0 + 3'd1;
    hi       = lo[2] ? hi1 : hi0;
    nib_sum  = {hi[1:0], lo[1:0]};
    nib_cout = hi[2];
    // The carry into the nibble's top bit is recovered from its sum bit.
    top_cin  = nib_sum[3] ^ na[3] ^ nb[3];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: NIB BUSY cycles, then one DONE cycle; start in DONE re-launches.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last)  state_next = DONE;
      DONE:    state_next = start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on an accepted start and nibble-by-nibble result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sub_reg   <= 1'b1;
      D         <= '0;
      V         <= 1'b0;
      Bout      <= 1'b0;
    end else if (accept) begin
      cnt_reg   <= '0;
      opa_reg   <= A;
      opb_reg   <= op_in ? ~B : B;
      carry_reg <= op_in;
      sub_reg   <= op_in;
    end else if (state_reg == BUSY) begin
      D[4*cnt_reg +: 4] <= nib_sum;
      carry_reg         <= nib_cout;
      cnt_reg           <= last ? '0 : cnt_reg + 1'b1;
      if (last) begin
        V    <= top_cin ^ nib_cout;
        Bout <= sub_reg ? ~nib_cout : nib_cout;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: directed and random checks of nibble_serial_sub (NIB=4)
// against an arithmetic reference model. Build with NSUB_ADD_MODE_EN to exercise add mode.
module tb_nibble_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, Bout, V;
  logic [15:0] D;

  int checks = 0;
  int errors = 0;

  nibble_serial_sub #(.NIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef NSUB_ADD_MODE_EN
    .op    (op),
`endif
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {Bout, V, D} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] s;
    logic        bo, v;
    if (sub) begin
      s  = {1'b0, a} - {1'b0, b};
      bo = (a < b);
      v  = (a[15] != b[15]) && (s[15] != a[15]);
    end else begin
      s  = {1'b0, a} + {1'b0, b};
      bo = s[16];
      v  = (a[15] == b[15]) && (s[15] != a[15]);
    end
    return {bo, v, s[15:0]};
  endfunction

  // One complete operation; optionally disturbs A/B/start while busy.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic opv, input bit disturb);
    logic [17:0] exp;
    exp = model(a, b, opv);
    @(negedge clk);
    A = a; B = b; op = opv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busy_c%0d", i + 1), busy, 1);
      check($sformatf("nodone_c%0d", i + 1), done, 0);
      if (disturb && i == 1) begin
        A = ~a; B = a ^ b; start = 1'b1;
      end
      if (disturb && i == 2) start = 1'b0;
      @(negedge clk);
    end
    check("done", done, 1);
    check("busy_off", busy, 0);
    check("D", D, exp[15:0]);
    check("V", V, exp[16]);
    check("Bout", Bout, exp[17]);
    $display("op a=%h b=%h sub=%0d -> D=%h V=%0d Bout=%0d", a, b, opv, D, V, Bout);
  endtask

  initial begin
    logic [17:0] exp;
    int t1, t2;
    logic [15:0] ra, rb, hold_d;
    logic        rop;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_D", D, 0);
    check("rst_V", V, 0);
    check("rst_Bout", Bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(16'h0005, 16'h0003, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);

    // Result holds while A/B change outside an accepted start
    hold_d = D;
    A = 16'h1111; B = 16'h2222;
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_done", done, 0);
    check("hold_D", D, hold_d);
    check("hold_V", V, 1);
    check("hold_Bout", Bout, 1);

    // Reset in second BUSY cycle
    @(negedge clk);
    A = 16'hABCD; B = 16'h0123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_V", V, 0);
    check("mid_rst_Bout", Bout, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_nodone", done, 0);
    end
    rst_n = 1'b1;
    do_op(16'h1234, 16'h0234, 1'b1, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    A = 16'h0100; B = 16'h0200; op = 1'b1; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done && t1 < 0) begin
        t1 = c;
        A = 16'h4321; B = 16'h1234;
      end else if (done && t2 < 0) begin
        t2 = c;
        break;
      end
    end
    start = 1'b0;
    exp = model(16'h4321, 16'h1234, 1'b1);
    check("b2b_first_latency", t1, 5);
    check("b2b_spacing", t2 - t1, 5);
    check("b2b_D", D, exp[15:0]);
    check("b2b_V", V, exp[16]);
    check("b2b_Bout", Bout, exp[17]);
    $display("b2b done at %0d and %0d, D=%h", t1, t2, D);
    @(negedge clk);

`ifdef NSUB_ADD_MODE_EN
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("add_D_zero", D, 0);
    check("add_Bout", Bout, 1);
    check("add_V", V, 0);
`endif

    // Random operations
    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef NSUB_ADD_MODE_EN
      rop = 1'($urandom_range(0, 1));
`else
      rop = 1'b1;
`endif
      do_op(ra, rb, rop, (n % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub.md
NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

Interface
REQ-001 The block SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port A, input, W, minuend, two's complement, captured on the accepted start.
REQ-006 The block SHALL have port B, input, W, subtrahend, two's complement, captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1, high while nibbles are being processed.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port D, output, W, result A-B (or A+B, see Configuration).
REQ-010 The block SHALL have port Bout, output, 1, unsigned borrow: inverse of final carry-out in subtract mode, carry-out itself in add mode.
REQ-011 The block SHALL have port V, output, 1, signed overflow flag.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY and DONE->BUSY on start=1; BUSY->DONE after NIB BUSY cycles; DONE->IDLE on start=0.
REQ-013 On an accepted start the block SHALL latch A and ~B (subtract) into operand registers, clear the nibble counter to 0, and set the carry register to 1.
REQ-014 Each BUSY cycle SHALL process nibble k (LSB first, k = counter) in carry-select form: lower 2 bits ripple from the carry register; upper 2 bits are computed for carry-in 0 and 1 in parallel and selected by the lower-half carry.
REQ-015 Each BUSY cycle SHALL write the 4-bit nibble sum into D[4k+3:4k], store the nibble carry-out in the carry register, and increment the counter.
REQ-016 On the last nibble (k = NIB-1) the block SHALL set V = carry into bit W-1 XOR carry out of bit W-1, and Bout per REQ-010.
REQ-017 done SHALL be 1 for exactly the one cycle spent in DONE; latency from the start-sampling edge to done high SHALL be NIB+1 cycles.
REQ-018 busy SHALL be 1 exactly in BUSY; start during BUSY SHALL be ignored and SHALL NOT disturb latched operands.
REQ-019 D, V, Bout SHALL hold their final values from DONE until the next accepted start; changes to A/B outside an accepted start SHALL have no effect.
REQ-020 start held high across DONE SHALL begin a new operation immediately (back-to-back, no IDLE cycle).
REQ-021 D bits of nibbles not yet processed in a running operation SHALL retain their prior values; only D after done is specified.

Reset
REQ-022 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, carry register 0, operand registers 0, D=0, V=0, Bout=0, busy=0, done=0.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst_n rises SHALL operate normally.

Configuration
REQ-024 With macro NSUB_ADD_MODE_EN defined, the block SHALL have an extra input op (1 bit, latched on accepted start): op=1 subtract per REQ-013, op=0 latch B uncomplemented with carry register 0, giving D = A+B.
REQ-025 Without NSUB_ADD_MODE_EN, port op SHALL not exist and the block SHALL always subtract.

Verification
REQ-026 NIB=4, A=16'h0005, B=16'h0003, start 1 cycle -> busy 4 cycles, done on 5th cycle, D=16'h0002, Bout=0, V=0.
REQ-027 A=16'h8000, B=16'h0001 -> D=16'h7FFF, V=1, Bout=0; A=16'h0000, B=16'h0001 -> D=16'hFFFF, V=0, Bout=1.
REQ-028 A=16'h7FFF, B=16'hFFFF -> D=16'h8000, V=1, Bout=1; change A/B and pulse start while busy -> result unchanged.
REQ-029 Assert rst_n=0 in 2nd BUSY cycle -> all outputs 0 at once, no done; next start A=16'h1234, B=16'h0234 -> D=16'h1000.
REQ-030 start held high through two operations -> done pulses 5 cycles apart, second result correct; with NSUB_ADD_MODE_EN, op=0, A=16'hFFFF, B=16'h0001 -> D=16'h0000, Bout=1, V=0.
